// File: rtl/msg_pkg.sv
// Shared definitions for the message sequencer: display codes, FSM encoding and
// the packed queue entry layout.
package msg_pkg;

    localparam int unsigned ENTRY_W = 9;

    localparam logic [3:0] CodeOff   = 4'd0;
    localparam logic [3:0] CodeDif1  = 4'd1;
    localparam logic [3:0] CodeDif2  = 4'd2;
    localparam logic [3:0] CodeDif3  = 4'd3;
    localparam logic [3:0] CodeVel1  = 4'd4;
    localparam logic [3:0] CodeVel2  = 4'd5;
    localparam logic [3:0] CodePc    = 4'd6;
    localparam logic [3:0] CodePvp   = 4'd7;
    localparam logic [3:0] CodeErro  = 4'd8;
    localparam logic [3:0] CodeSuss  = 4'd9;
    localparam logic [3:0] CodeDigi  = 4'd10;
    localparam logic [3:0] CodeResp  = 4'd11;
    localparam logic [3:0] CodeAll0  = 4'd12;
    localparam logic [3:0] CodeBlank = 4'd13;
    localparam logic [3:0] CodeCont  = 4'd14;

    typedef enum logic [1:0] {
        StIdle,
        StShow,
        StGap
    } msg_state_e;

    typedef struct packed {
        logic       blink;
        logic [3:0] dur;
        logic [3:0] code;
    } msg_entry_t;

endpackage

// File: rtl/msg_fifo.sv
// Synchronous request queue with first-word-fall-through read data and a
// flush that empties it on the next edge.
module msg_fifo
    import msg_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push_i,
    input  logic               pop_i,
    input  logic               flush_i,
    input  logic [ENTRY_W-1:0] wdata_i,
    output logic [ENTRY_W-1:0] rdata_o,
    output logic               full_o,
    output logic               empty_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [ENTRY_W-1:0] mem_d [DEPTH];
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic               do_push, do_pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o && !flush_i;
    assign do_pop  = pop_i && !empty_o && !flush_i;
    assign rdata_o = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = wdata_i;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            // Simultaneous push and pop leaves the occupancy unchanged.
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/msg_sequencer.sv
// Plays queued display messages onto a 7-segment code output, with tick-based
// durations, an inter-message blank gap, optional blinking and a flush.
module msg_sequencer
    import msg_pkg::*;
#(
    parameter int unsigned TICK_DIV   = 5000000,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [3:0] req_code,
    input  logic [3:0] req_dur,
    input  logic       req_blink,
    input  logic [3:0] idle_code,
    input  logic       flush,
    output logic [3:0] X,
    output logic       busy
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    msg_state_e         state_q, state_d;
    logic [3:0]         x_q, x_d;
    logic [PW-1:0]      presc_q, presc_d;
    logic [3:0]         tick_cnt_q, tick_cnt_d;
    logic               phase_q, phase_d;
    msg_entry_t         cur_q, cur_d;

    msg_entry_t         push_entry, fifo_head;
    logic [ENTRY_W-1:0] fifo_rdata;
    logic               fifo_full, fifo_empty, fifo_pop;
    logic               tick, expire, load;

    assign push_entry = '{blink: req_blink, dur: req_dur, code: req_code};
    assign fifo_head  = msg_entry_t'(fifo_rdata);
    assign req_ready  = !fifo_full && !flush;
    assign busy       = (state_q != StIdle) || !fifo_empty;
    assign X          = x_q;

    msg_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .push_i (req_valid && req_ready),
        .pop_i  (fifo_pop),
        .flush_i(flush),
        .wdata_i(push_entry),
        .rdata_o(fifo_rdata),
        .full_o (fifo_full),
        .empty_o(fifo_empty)
    );

    assign tick = (state_q != StIdle) && (presc_q == PW'(TICK_DIV - 1));
    // Sticky messages end only when something is waiting behind them.
    assign expire = (cur_q.dur != 4'd0) ? (tick_cnt_q == cur_q.dur - 4'd1) : !fifo_empty;

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        tick_cnt_d = tick_cnt_q;
        phase_d    = phase_q;
        cur_d      = cur_q;
        fifo_pop   = 1'b0;
        load       = 1'b0;
        presc_d    = '0;
        if (state_q != StIdle) begin
            presc_d = tick ? '0 : presc_q + PW'(1);
        end

        if (flush) begin
            state_d    = StIdle;
            x_d        = idle_code;
            presc_d    = '0;
            tick_cnt_d = '0;
            phase_d    = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    x_d  = idle_code;
                    load = !fifo_empty;
                end
                StShow: begin
                    if (tick && expire) begin
                        state_d = fifo_empty ? StIdle : StGap;
                        x_d     = fifo_empty ? idle_code : CodeBlank;
                    end else if (tick) begin
                        if (cur_q.dur != 4'd0) begin
                            tick_cnt_d = tick_cnt_q + 4'd1;
                        end
                        if (cur_q.blink) begin
                            phase_d = !phase_q;
                            x_d     = phase_q ? cur_q.code : CodeBlank;
                        end
                    end
                end
                StGap: begin
                    if (tick) begin
                        load = !fifo_empty;
                        if (fifo_empty) begin
                            state_d = StIdle;
                            x_d     = idle_code;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase

            if (load) begin
                fifo_pop   = 1'b1;
                cur_d      = fifo_head;
                x_d        = fifo_head.code;
                presc_d    = '0;
                tick_cnt_d = '0;
                phase_d    = 1'b0;
                state_d    = StShow;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            x_q        <= CodeBlank;
            presc_q    <= '0;
            tick_cnt_q <= '0;
            phase_q    <= 1'b0;
            cur_q      <= '0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            presc_q    <= presc_d;
            tick_cnt_q <= tick_cnt_d;
            phase_q    <= phase_d;
            cur_q      <= cur_d;
        end
    end

endmodule

// File: tb/tb_msg_sequencer.sv
// Scoreboard bench for msg_sequencer: scenarios queue per-cycle expected X/busy
// values, and a monitor pops and compares one entry after every rising edge.
module tb_msg_sequencer;

    typedef struct packed {
        logic [3:0] x;
        logic       busy;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic [3:0] req_code;
    logic [3:0] req_dur;
    logic       req_blink;
    logic [3:0] idle_code;
    logic       flush;
    logic [3:0] X;
    logic       busy;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cycle    = 0;

    msg_sequencer #(
        .TICK_DIV  (4),
        .FIFO_DEPTH(4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_code (req_code),
        .req_dur  (req_dur),
        .req_blink(req_blink),
        .idle_code(idle_code),
        .flush    (flush),
        .X        (X),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always begin : monitor
        exp_t e;
        @(posedge clk);
        #1;
        cycle++;
        if (rst_n && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if (X !== e.x) begin
                failures++;
                $display("FAIL x cycle %0d: got %0d expected %0d", cycle, X, e.x);
            end
            checks++;
            if (busy !== e.busy) begin
                failures++;
                $display("FAIL busy cycle %0d: got %0b expected %0b", cycle, busy, e.busy);
            end
        end
    end

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    task automatic push_exp(input logic [3:0] xv, input logic bv, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back('{x: xv, busy: bv});
    endtask

    // Leaves req_valid high so the caller can chain back-to-back requests.
    task automatic send_req(input logic [3:0] code, input logic [3:0] dur, input logic blink);
        int n = 0;
        req_valid = 1'b1;
        req_code  = code;
        req_dur   = dur;
        req_blink = blink;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            checks++;
            failures++;
            $display("FAIL accept code %0d: ready got 0 expected 1", code);
        end
        @(negedge clk);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_code  = '0;
        req_dur   = '0;
        req_blink = 1'b0;
        idle_code = 4'd12;
        flush     = 1'b0;

        // Reset state, then idle code after release.
        repeat (3) @(negedge clk);
        check("reset_x", X, 4'd13);
        check("reset_ready", {3'b0, req_ready}, 4'd1);
        check("reset_busy", {3'b0, busy}, 4'd0);
        push_exp(4'd12, 1'b0, 3);
        rst_n = 1'b1;
        wait_drain();

        // Single message, code 8 for two ticks.
        push_exp(4'd12, 1'b1, 1);
        push_exp(4'd8, 1'b1, 8);
        push_exp(4'd12, 1'b0, 2);
        send_req(4'd8, 4'd2, 1'b0);
        req_valid = 1'b0;
        wait_drain();

        // Back-to-back messages separated by a one-tick blank gap.
        push_exp(4'd12, 1'b1, 1);
        push_exp(4'd9, 1'b1, 4);
        push_exp(4'd13, 1'b1, 4);
        push_exp(4'd14, 1'b1, 4);
        push_exp(4'd12, 1'b0, 2);
        send_req(4'd9, 4'd1, 1'b0);
        send_req(4'd14, 4'd1, 1'b0);
        req_valid = 1'b0;
        wait_drain();

        // Blinking message.
        push_exp(4'd12, 1'b1, 1);
        push_exp(4'd4, 1'b1, 4);
        push_exp(4'd13, 1'b1, 4);
        push_exp(4'd4, 1'b1, 4);
        push_exp(4'd13, 1'b1, 4);
        push_exp(4'd12, 1'b0, 2);
        send_req(4'd4, 4'd4, 1'b1);
        req_valid = 1'b0;
        wait_drain();

        // Code above 14 passes through untouched.
        push_exp(4'd12, 1'b1, 1);
        push_exp(4'd15, 1'b1, 4);
        push_exp(4'd12, 1'b0, 2);
        send_req(4'd15, 4'd1, 1'b0);
        req_valid = 1'b0;
        wait_drain();

        // Sticky message with a full queue behind it.
        push_exp(4'd12, 1'b1, 1);
        push_exp(4'd10, 1'b1, 4);
        push_exp(4'd13, 1'b1, 4);
        push_exp(4'd1, 1'b1, 4);
        push_exp(4'd13, 1'b1, 4);
        push_exp(4'd2, 1'b1, 4);
        push_exp(4'd13, 1'b1, 4);
        push_exp(4'd3, 1'b1, 4);
        push_exp(4'd13, 1'b1, 4);
        push_exp(4'd5, 1'b1, 4);
        push_exp(4'd13, 1'b1, 4);
        push_exp(4'd6, 1'b1, 4);
        push_exp(4'd12, 1'b0, 2);
        send_req(4'd10, 4'd0, 1'b0);
        send_req(4'd1, 4'd1, 1'b0);
        send_req(4'd2, 4'd1, 1'b0);
        send_req(4'd3, 4'd1, 1'b0);
        send_req(4'd5, 4'd1, 1'b0);
        check("full_ready", {3'b0, req_ready}, 4'd0);
        send_req(4'd6, 4'd1, 1'b0);
        req_valid = 1'b0;
        wait_drain();

        // Flush mid-show with three entries queued; a same-cycle push is dropped.
        push_exp(4'd12, 1'b1, 1);
        push_exp(4'd8, 1'b1, 5);
        push_exp(4'd12, 1'b0, 10);
        send_req(4'd8, 4'd4, 1'b0);
        send_req(4'd1, 4'd1, 1'b0);
        send_req(4'd2, 4'd1, 1'b0);
        send_req(4'd3, 4'd1, 1'b0);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        flush     = 1'b1;
        req_valid = 1'b1;
        req_code  = 4'd7;
        req_dur   = 4'd1;
        #1;
        check("flush_ready_low", {3'b0, req_ready}, 4'd0);
        @(negedge clk);
        flush     = 1'b0;
        req_valid = 1'b0;
        #1;
        check("post_flush_ready", {3'b0, req_ready}, 4'd1);
        check("post_flush_busy", {3'b0, busy}, 4'd0);
        wait_drain();

        // Reset in the middle of a show discards everything.
        push_exp(4'd12, 1'b1, 1);
        push_exp(4'd5, 1'b1, 5);
        send_req(4'd5, 4'd3, 1'b0);
        req_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midreset_x", X, 4'd13);
        check("midreset_busy", {3'b0, busy}, 4'd0);
        check("midreset_ready", {3'b0, req_ready}, 4'd1);
        repeat (2) @(negedge clk);
        push_exp(4'd12, 1'b0, 12);
        rst_n = 1'b1;
        wait_drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
